seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised serial bit-pattern detector with a Moore output, a runtime overlap/non-overlap mode, an input-valid qualifier and a saturating match counter. It is the general successor to the fixed 11011 overlapping Moore detector. It sits on a one-bit serial stream and flags each completed occurrence of a compile-time pattern of any length from 2 to 32. Downstream logic uses `out` as a one-cycle-per-match indicator and reads `match_cnt` for statistics.

## Interface
- `SEQ_W`, 5: pattern length in bits; legal range 2..32.
- `PATTERN`, 5'b11011: pattern value, `SEQ_W` bits wide. `PATTERN[SEQ_W-1]` is the first bit expected on the stream.
- `CNT_W`, 8: width of the match counter.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in`  input  1  serial data bit; sampled only when `in_valid`=1.
- `in_valid`  input  1  qualifies `in`. When 0, all state holds.
- `overlap`  input  1  1 = overlapping detection, 0 = non-overlapping. Sampled every cycle.
- `clr_cnt`  input  1  synchronous clear of `match_cnt`.
- `out`  output  1  Moore match flag; 1 exactly when state S = `SEQ_W`.
- `match_cnt`  output  `CNT_W`  number of matches since reset or clear; saturates at all-ones.
- `prefix_len`  output  $clog2(SEQ_W+1)  current state S, for debug.

## Operation
- State S is in 0..`SEQ_W`. S is the length of the longest prefix of `PATTERN` that equals a suffix of the bits accepted since the last reset or restart.
- Store a history register of the last `SEQ_W` accepted bits plus a valid-length count `hlen` (0..`SEQ_W`). Bits older than `hlen` never participate in matching.
- When S < `SEQ_W` and `in_valid`=1:
  - Shift `in` into the history and set `hlen` = min(`hlen`+1, `SEQ_W`).
  - Next S = the largest k ≤ min(`hlen`, `SEQ_W`) such that the last k history bits equal `PATTERN[SEQ_W-1 -: k]`. k=0 is always valid.
- When S = `SEQ_W`, `in_valid`=1 and `overlap`=1: use the same rule on the full history. The failure function reuses matched bits.
- When S = `SEQ_W`, `in_valid`=1 and `overlap`=0: restart.
  - Clear the history and set `hlen`=1 holding `in`.
  - Next S = 1 if `in` = `PATTERN[SEQ_W-1]`, else 0.
- `in_valid`=0: S, history, `hlen`, `out` and `match_cnt` all hold. A held S=`SEQ_W` keeps `out`=1.
- A match event is any accepted bit that moves S to `SEQ_W`, including `SEQ_W`→`SEQ_W` for self-overlapping patterns.
- `match_cnt` on a match event increments by 1, saturating at 2^`CNT_W`-1 with no wrap.
- `clr_cnt`=1 loads 0, or loads 1 if a match event occurs in the same cycle.
- `overlap` changes take effect only on a transition out of S=`SEQ_W`; they never disturb a partial match.

## Timing
- Reset values: S=0, history=0, `hlen`=0, `out`=0, `match_cnt`=0, `prefix_len`=0.
- Reset asserted mid-stream discards any partial match immediately and asynchronously. The first accepted bit after release counts as bit 1 of a new stream.
- `out` is a registered state decode, with no combinational path from `in`. If the final pattern bit is sampled at edge N, `out`=1 from edge N until the next edge that accepts a bit.
- With continuous `in_valid`=1, `out` is a 1-cycle pulse per match. It is high on consecutive cycles only for self-overlapping patterns in overlap mode, e.g. 111 on stream 1111.
- `match_cnt` updates at the same edge N that raises `out`.
- The earliest possible match is the `SEQ_W`-th accepted bit after reset.
- In non-overlap mode, a new match needs `SEQ_W` fresh bits after the previous match.

## Test plan
- Default parameters, `overlap`=1, stream 1,1,0,1,1,0,1,1 with continuous valid → `out` pulses after bits 5 and 8; `match_cnt`=2.
- Default parameters, `overlap`=0, stream 1,1,0,1,1,0,1,1,0,1,1 → `out` pulses after bits 5 and 11 only; `match_cnt`=2.
- `SEQ_W`=3, `PATTERN`=3'b111:
  - `overlap`=1, stream 1,1,1,1 → `out` high for 2 consecutive cycles; `match_cnt`=2.
  - `overlap`=0, stream 1×6 → pulses after bits 3 and 6.
- Default parameters, stream 1,1,0,1 with `in_valid` dropped for 4 cycles, then 1 → `prefix_len` holds at 4 during the gap; a single `out` pulse after the last bit; `match_cnt`=1.
- `CNT_W`=2, 5 overlapping matches → `match_cnt` reads 1,2,3,3,3. Then `clr_cnt`=1 in the same cycle as a match → `match_cnt`=1.
- Assert `rst` asynchronously after 1,1,0,1, release, then send 1 → no match; `out`=0 and `prefix_len`=1.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: Moore match flag, runtime overlap mode,
// input-valid qualifier and a saturating match counter.
module seq_detect_param #(
    parameter int                SEQ_W   = 5,
    parameter logic [SEQ_W-1:0]  PATTERN = 5'b11011,
    parameter int                CNT_W   = 8,
    localparam int               LW      = $clog2(SEQ_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LW-1:0]    prefix_len
);

    localparam logic [LW-1:0]    FULL = LW'(SEQ_W);
    localparam logic [SEQ_W-1:0] ONES = {SEQ_W{1'b1}};

    logic [SEQ_W-1:0] hist, nxt_hist;
    logic [LW-1:0]    hlen, nxt_hlen;
    logic [LW-1:0]    s, nxt_s;
    logic             restart;
    logic             match;

    assign restart    = (s == FULL) && !overlap;
    assign prefix_len = s;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nxt_hist = hist;
        nxt_hlen = hlen;
        nxt_s    = '0;
        if (restart) begin
            nxt_hist = {{(SEQ_W-1){1'b0}}, in};
            nxt_hlen = LW'(1);
            nxt_s    = (in == PATTERN[SEQ_W-1]) ? LW'(1) : '0;
        end else begin
            nxt_hist = {hist[SEQ_W-2:0], in};
            nxt_hlen = (hlen == FULL) ? hlen : hlen + 1'b1;
            // Longest prefix of PATTERN that is a suffix of the valid history; later k wins.
            for (int k = 1; k <= SEQ_W; k++) begin
                if (k <= int'(nxt_hlen) &&
                    ((nxt_hist & (ONES >> (SEQ_W - k))) == (PATTERN >> (SEQ_W - k))))
                    nxt_s = LW'(k);
            end
        end
    end

    assign match = in_valid && (nxt_s == FULL);

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= '0;
            hist      <= '0;
            hlen      <= '0;
            out       <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (in_valid) begin
                s    <= nxt_s;
                hist <= nxt_hist;
                hlen <= nxt_hlen;
                out  <= match;
            end
            if (clr_cnt)
                match_cnt <= match ? CNT_W'(1) : '0;
            else if (match && match_cnt != {CNT_W{1'b1}})
                match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule
